// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter shared by the instruction fetch and data memory ports.
// A three-state FSM (IDLE -> ACCESS -> RESP) serves one transfer at a time.
// Each transfer holds the SRAM for WAIT_CYCLES cycles, then pulses the owner's ready.
// WAIT_CYCLES must lie in 1..7 because the wait counter is three bits wide.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_rd_req,
    input  logic        dm_wr_req,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        freeze_if,
    output logic        freeze_pipe,
    output logic        sram_en,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter value seen in the final SRAM access cycle.
    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_dm_q, last_dm_d;   // previous grant went to the data port
    logic        gnt_dm_q, gnt_dm_d;     // current transfer belongs to the data port
    logic        wr_q, wr_d;             // current transfer is a write
    logic [29:0] addr_q, addr_d;         // latched word address
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        dm_ready_q, dm_ready_d;

    logic        dm_req;
    logic        pick_dm;

    // Byte-offset bits are irrelevant to a word-wide SRAM.
    logic        unused_byte_bits;
    assign unused_byte_bits = &{1'b0, if_addr[1:0], dm_addr[1:0]};

    assign dm_req = dm_rd_req | dm_wr_req;

    // Data wins unless fetch is also waiting and data had the previous grant.
    assign pick_dm = dm_req & ~(if_req & last_dm_q);

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            last_dm_q  <= 1'b0;
            gnt_dm_q   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 30'd0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dm_q  <= last_dm_d;
            gnt_dm_q   <= gnt_dm_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
        end
    end

    // Next-state logic: grant in IDLE, count SRAM cycles in ACCESS, release in RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_dm_d  = last_dm_q;
        gnt_dm_d   = gnt_dm_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req | dm_req) begin
                    gnt_dm_d  = pick_dm;
                    last_dm_d = pick_dm;
                    cnt_d     = 3'd0;
                    state_d   = ACCESS;
                    if (pick_dm) begin
                        addr_d  = dm_addr[31:2];
                        wdata_d = dm_wdata;
                        // A simultaneous read and write request is a write.
                        wr_d    = dm_wr_req;
                    end else begin
                        addr_d  = if_addr[31:2];
                        wr_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                    if (!wr_q) begin
                        if (gnt_dm_q) begin
                            dm_rdata_d = sram_rdata;
                        end else begin
                            if_rdata_d = sram_rdata;
                        end
                    end
                    // Ready is registered so it is high exactly during RESP.
                    if_ready_d = ~gnt_dm_q;
                    dm_ready_d = gnt_dm_q;
                end
            end
            RESP: begin
                // Always return to IDLE so a new grant costs one arbitration cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sram_en     = (state_q == ACCESS);
    assign sram_we     = (state_q == ACCESS) & wr_q;
    assign sram_addr   = {addr_q, 2'b00};
    assign sram_wdata  = wdata_q;

    assign if_ready    = if_ready_q;
    assign dm_ready    = dm_ready_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;

    assign freeze_if   = if_req & ~if_ready_q;
    assign freeze_pipe = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a cycle-by-cycle vector table on a WAIT_CYCLES=2
// instance, plus fetch latency sweeps on WAIT_CYCLES=1 and WAIT_CYCLES=7 instances.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_rd_req;
    logic        dm_wr_req;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        if_ready, dm_ready, freeze_if, freeze_pipe, sram_en, sram_we;
    logic [31:0] if_rdata, dm_rdata, sram_addr, sram_wdata, sram_rdata;

    // Sweep instances: fetch-only stimulus, data inputs tied off.
    logic        zero1  = 1'b0;
    logic [31:0] zero32 = 32'd0;
    logic [31:0] sw_addr;
    logic        if_req_w1, if_ready_w1, dm_ready_w1, freeze_if_w1, freeze_pipe_w1;
    logic        sram_en_w1, sram_we_w1;
    logic [31:0] if_rdata_w1, dm_rdata_w1, sram_addr_w1, sram_wdata_w1, sram_rdata_w1;
    logic        if_req_w7, if_ready_w7, dm_ready_w7, freeze_if_w7, freeze_pipe_w7;
    logic        sram_en_w7, sram_we_w7;
    logic [31:0] if_rdata_w7, dm_rdata_w7, sram_addr_w7, sram_wdata_w7, sram_rdata_w7;

    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_rd_req(dm_rd_req), .dm_wr_req(dm_wr_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .freeze_if(freeze_if), .freeze_pipe(freeze_pipe),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    mem_port_arbiter #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst),
        .if_req(if_req_w1), .if_addr(sw_addr), .if_ready(if_ready_w1), .if_rdata(if_rdata_w1),
        .dm_rd_req(zero1), .dm_wr_req(zero1), .dm_addr(zero32), .dm_wdata(zero32),
        .dm_ready(dm_ready_w1), .dm_rdata(dm_rdata_w1),
        .freeze_if(freeze_if_w1), .freeze_pipe(freeze_pipe_w1),
        .sram_en(sram_en_w1), .sram_we(sram_we_w1), .sram_addr(sram_addr_w1),
        .sram_wdata(sram_wdata_w1), .sram_rdata(sram_rdata_w1)
    );

    mem_port_arbiter #(.WAIT_CYCLES(7)) u_w7 (
        .clk(clk), .rst(rst),
        .if_req(if_req_w7), .if_addr(sw_addr), .if_ready(if_ready_w7), .if_rdata(if_rdata_w7),
        .dm_rd_req(zero1), .dm_wr_req(zero1), .dm_addr(zero32), .dm_wdata(zero32),
        .dm_ready(dm_ready_w7), .dm_rdata(dm_rdata_w7),
        .freeze_if(freeze_if_w7), .freeze_pipe(freeze_pipe_w7),
        .sram_en(sram_en_w7), .sram_we(sram_we_w7), .sram_addr(sram_addr_w7),
        .sram_wdata(sram_wdata_w7), .sram_rdata(sram_rdata_w7)
    );

    // SRAM model for the main instance: combinational read, write on the clock edge.
    assign sram_rdata = mem[sram_addr[11:2]];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[1]   = 32'hE3A01004;
        mem[2]   = 32'h11112222;
        mem[3]   = 32'h55556666;
        mem[4]   = 32'h33334444;
        mem[5]   = 32'h77778888;
        mem[8]   = 32'h0BADF00D;
        mem[9]   = 32'h9999AAAA;
        mem[256] = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            if (sram_en && sram_we) mem[sram_addr[11:2]] <= sram_wdata;
        end
    end

    // Sweep SRAMs return a fixed pattern derived from the address.
    assign sram_rdata_w1 = sram_addr_w1 ^ 32'h5A5A0000;
    assign sram_rdata_w7 = sram_addr_w7 ^ 32'h5A5A0000;

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_rd;
        logic        dm_wr;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        e_if_rdy;
        logic        e_dm_rdy;
        logic        e_frz_if;
        logic        e_frz_pipe;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_saddr;
        logic [31:0] e_if_rdata;
        logic [31:0] e_dm_rdata;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_ird = 32'd0;
    logic [31:0] exp_drd = 32'd0;

    task automatic add(input logic r, input logic iq, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic ir, input logic dy,
                       input logic fi, input logic fp, input logic en, input logic we,
                       input logic [31:0] sa);
        vec_t v;
        v.rst = r; v.if_req = iq; v.if_addr = ia; v.dm_rd = dr; v.dm_wr = dw;
        v.dm_addr = da; v.dm_wdata = dwd; v.e_if_rdy = ir; v.e_dm_rdy = dy;
        v.e_frz_if = fi; v.e_frz_pipe = fp; v.e_en = en; v.e_we = we; v.e_saddr = sa;
        v.e_if_rdata = exp_ird; v.e_dm_rdata = exp_drd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fill_table();
        logic [31:0] prev;
        logic [31:0] sa;
        logic        f;
        // Fetch of byte address 0x6 -> word 0x4.
        add(1,1,32'h6, 0,0,0,0, 0,0, 1,0, 0,0, 32'h0);
        add(1,1,32'h6, 0,0,0,0, 0,0, 1,0, 1,0, 32'h4);
        add(1,1,32'h6, 0,0,0,0, 0,0, 1,0, 1,0, 32'h4);
        exp_ird = 32'hE3A01004;
        add(1,1,32'h6, 0,0,0,0, 1,0, 0,0, 0,0, 32'h4);
        // Contention after a fetch grant: data first, then fetch.
        add(1,1,32'h8, 1,0,32'h10,0, 0,0, 1,1, 0,0, 32'h4);
        add(1,1,32'h8, 1,0,32'h10,0, 0,0, 1,1, 1,0, 32'h10);
        add(1,1,32'h8, 1,0,32'h10,0, 0,0, 1,1, 1,0, 32'h10);
        exp_drd = 32'h33334444;
        add(1,1,32'h8, 1,0,32'h10,0, 0,1, 1,0, 0,0, 32'h10);
        add(1,1,32'h8, 0,0,32'h10,0, 0,0, 1,0, 0,0, 32'h10);
        add(1,1,32'h8, 0,0,32'h10,0, 0,0, 1,0, 1,0, 32'h8);
        add(1,1,32'h8, 0,0,32'h10,0, 0,0, 1,0, 1,0, 32'h8);
        exp_ird = 32'h11112222;
        add(1,1,32'h8, 0,0,32'h10,0, 1,0, 0,0, 0,0, 32'h8);
        // Data write of 0x2000 to 0x400, then read it back.
        add(1,0,0, 0,1,32'h400,32'h2000, 0,0, 0,1, 0,0, 32'h8);
        add(1,0,0, 0,1,32'h400,32'h2000, 0,0, 0,1, 1,1, 32'h400);
        add(1,0,0, 0,1,32'h400,32'h2000, 0,0, 0,1, 1,1, 32'h400);
        add(1,0,0, 0,1,32'h400,32'h2000, 0,1, 0,0, 0,0, 32'h400);
        add(1,0,0, 1,0,32'h400,0, 0,0, 0,1, 0,0, 32'h400);
        add(1,0,0, 1,0,32'h400,0, 0,0, 0,1, 1,0, 32'h400);
        add(1,0,0, 1,0,32'h400,0, 0,0, 0,1, 1,0, 32'h400);
        exp_drd = 32'h00002000;
        add(1,0,0, 1,0,32'h400,0, 0,1, 0,0, 0,0, 32'h400);
        add(1,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 32'h400);
        // Sustained load after a data grant: F, D, F, D.
        prev = 32'h400;
        for (int k = 0; k < 4; k++) begin
            f  = (k % 2 == 0);
            sa = f ? 32'hC : 32'h14;
            add(1,1,32'hC, 1,0,32'h14,0, 0,0, 1,1, 0,0, prev);
            add(1,1,32'hC, 1,0,32'h14,0, 0,0, 1,1, 1,0, sa);
            add(1,1,32'hC, 1,0,32'h14,0, 0,0, 1,1, 1,0, sa);
            if (f) exp_ird = 32'h55556666;
            else   exp_drd = 32'h77778888;
            add(1,1,32'hC, 1,0,32'h14,0, f,~f, ~f,f, 0,0, sa);
            prev = sa;
        end
        add(1,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 32'h14);
        // Write request withdrawn after one cycle still completes.
        add(1,0,0, 0,1,32'h20,32'hCAFEF00D, 0,0, 0,1, 0,0, 32'h14);
        add(1,0,0, 0,0,0,0, 0,0, 0,0, 1,1, 32'h20);
        add(1,0,0, 0,0,0,0, 0,0, 0,0, 1,1, 32'h20);
        add(1,0,0, 0,0,0,0, 0,1, 0,0, 0,0, 32'h20);
        add(1,1,32'h20, 0,0,0,0, 0,0, 1,0, 0,0, 32'h20);
        add(1,1,32'h20, 0,0,0,0, 0,0, 1,0, 1,0, 32'h20);
        add(1,1,32'h20, 0,0,0,0, 0,0, 1,0, 1,0, 32'h20);
        exp_ird = 32'hCAFEF00D;
        add(1,1,32'h20, 0,0,0,0, 1,0, 0,0, 0,0, 32'h20);
        // Reset in the second access cycle of a fetch aborts it.
        add(1,1,32'h24, 0,0,0,0, 0,0, 1,0, 0,0, 32'h20);
        add(1,1,32'h24, 0,0,0,0, 0,0, 1,0, 1,0, 32'h24);
        add(0,1,32'h24, 0,0,0,0, 0,0, 1,0, 1,0, 32'h24);
        exp_ird = 32'd0;
        exp_drd = 32'd0;
        add(1,1,32'h24, 0,0,0,0, 0,0, 1,0, 0,0, 32'h0);
        add(1,1,32'h24, 0,0,0,0, 0,0, 1,0, 1,0, 32'h24);
        add(1,1,32'h24, 0,0,0,0, 0,0, 1,0, 1,0, 32'h24);
        exp_ird = 32'h9999AAAA;
        add(1,1,32'h24, 0,0,0,0, 1,0, 0,0, 0,0, 32'h24);
        add(1,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 32'h24);
    endtask

    // Fetch 0x1C on a sweep instance and measure ready latency and enable length.
    task automatic sweep(input int w);
        int          rdy_cyc = -1;
        int          en_cnt  = 0;
        logic [31:0] rd      = 32'd0;
        logic        rdy;
        logic        en;
        @(posedge clk); #1;
        sw_addr = 32'h1C;
        if (w == 1) if_req_w1 = 1'b1; else if_req_w7 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (rdy_cyc >= 0) begin
                    if_req_w1 = 1'b0;
                    if_req_w7 = 1'b0;
                end
            end
            @(negedge clk);
            rdy = (w == 1) ? if_ready_w1 : if_ready_w7;
            en  = (w == 1) ? sram_en_w1  : sram_en_w7;
            if (en) en_cnt++;
            if (rdy && rdy_cyc < 0) begin
                rdy_cyc = c;
                rd = (w == 1) ? if_rdata_w1 : if_rdata_w7;
            end
        end
        if_req_w1 = 1'b0;
        if_req_w7 = 1'b0;
        chk($sformatf("sweep%0d ready_cycle", w), 32'(rdy_cyc), 32'(w + 1));
        chk($sformatf("sweep%0d en_cycles", w), 32'(en_cnt), 32'(w));
        chk($sformatf("sweep%0d if_rdata", w), rd, 32'h5A5A001C);
        $display("sweep W=%0d: ready at cycle %0d, sram_en cycles %0d, rdata 0x%08h",
                 w, rdy_cyc, en_cnt, rd);
    endtask

    initial begin
        int bad0;
        rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_rd_req = 1'b0; dm_wr_req = 1'b0;
        dm_addr = '0; dm_wdata = '0; sw_addr = '0; if_req_w1 = 1'b0; if_req_w7 = 1'b0;
        fill_table();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset if_ready", 32'(if_ready), 32'd0);
        chk("reset dm_ready", 32'(dm_ready), 32'd0);
        chk("reset sram_en", 32'(sram_en), 32'd0);
        chk("reset sram_we", 32'(sram_we), 32'd0);
        chk("reset sram_addr", sram_addr, 32'd0);
        chk("reset sram_wdata", sram_wdata, 32'd0);
        chk("reset if_rdata", if_rdata, 32'd0);
        chk("reset dm_rdata", dm_rdata, 32'd0);
        chk("reset w1 sram_en", 32'(sram_en_w1), 32'd0);
        chk("reset w7 sram_en", 32'(sram_en_w7), 32'd0);
        $display("reset: if_ready=%0d dm_ready=%0d sram_en=%0d sram_addr=0x%08h",
                 if_ready, dm_ready, sram_en, sram_addr);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst       = vecs[i].rst;
            if_req    = vecs[i].if_req;
            if_addr   = vecs[i].if_addr;
            dm_rd_req = vecs[i].dm_rd;
            dm_wr_req = vecs[i].dm_wr;
            dm_addr   = vecs[i].dm_addr;
            dm_wdata  = vecs[i].dm_wdata;
            @(negedge clk);
            bad0 = n_bad;
            chk($sformatf("row%0d if_ready", i), 32'(if_ready), 32'(vecs[i].e_if_rdy));
            chk($sformatf("row%0d dm_ready", i), 32'(dm_ready), 32'(vecs[i].e_dm_rdy));
            chk($sformatf("row%0d freeze_if", i), 32'(freeze_if), 32'(vecs[i].e_frz_if));
            chk($sformatf("row%0d freeze_pipe", i), 32'(freeze_pipe), 32'(vecs[i].e_frz_pipe));
            chk($sformatf("row%0d sram_en", i), 32'(sram_en), 32'(vecs[i].e_en));
            chk($sformatf("row%0d sram_we", i), 32'(sram_we), 32'(vecs[i].e_we));
            chk($sformatf("row%0d sram_addr", i), sram_addr, vecs[i].e_saddr);
            chk($sformatf("row%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
            chk($sformatf("row%0d dm_rdata", i), dm_rdata, vecs[i].e_dm_rdata);
            $display("row %0d: rst=%0d if_req=%0d dm_rd=%0d dm_wr=%0d en=%0d we=%0d addr=0x%08h if_rdy=%0d dm_rdy=%0d errors=%0d",
                     i, rst, if_req, dm_rd_req, dm_wr_req, sram_en, sram_we, sram_addr,
                     if_ready, dm_ready, n_bad - bad0);
        end

        sweep(1);
        sweep(7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: WAIT_CYCLES, default 2, SRAM access cycles per transfer with legal range 1..7.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-low reset.
REQ-005 if_req  in  1  fetch request; held by the fetch stage until if_ready.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_ready  out  1  one-cycle pulse: if_rdata valid.
REQ-008 if_rdata  out  32  fetched instruction, registered.
REQ-009 dm_rd_req, dm_wr_req  in  1 each  data read/write request; held until dm_ready.
REQ-010 dm_addr, dm_wdata  in  32 each  data byte address and store data.
REQ-011 dm_ready  out  1  one-cycle pulse: data transfer complete.
REQ-012 dm_rdata  out  32  load data, registered.
REQ-013 freeze_if  out  1  stall for the PC register and the IF stage.
REQ-014 freeze_pipe  out  1  stall for the pipeline from MEM and earlier stages.
REQ-015 sram_en, sram_we  out  1 each  SRAM access enable and write enable.
REQ-016 sram_addr, sram_wdata  out  32 each  word address and write data.
REQ-017 sram_rdata  in  32  SRAM read data, valid in the last access cycle.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-019 In IDLE with any request pending, the block SHALL grant one requester, latch its address, write data and direction (fetch = read), clear the wait counter and go to ACCESS.
REQ-020 Arbitration SHALL give data priority over fetch, except when the previous grant was data and both request, in which case fetch SHALL win.
REQ-021 dm_wr_req together with dm_rd_req SHALL be treated as a write.
REQ-022 In ACCESS, sram_en SHALL be 1 and sram_addr SHALL be {latched_addr[31:2],2'b00}.
REQ-023 In ACCESS, sram_we SHALL be 1 only for a data write; sram_wdata SHALL be the latched data.
REQ-024 The 3-bit wait counter SHALL increment each ACCESS cycle.
REQ-025 When the counter equals WAIT_CYCLES-1, the block SHALL register sram_rdata into if_rdata or dm_rdata (reads only) and go to RESP.
REQ-026 In RESP, the block SHALL pulse the granted requester's ready for exactly one cycle and go to IDLE unconditionally, with no back-to-back grant from RESP.
REQ-027 Latency SHALL be: request seen in IDLE at cycle 0 -> ready at cycle WAIT_CYCLES+1; throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-028 freeze_if SHALL equal if_req & ~if_ready, combinationally.
REQ-029 freeze_pipe SHALL equal (dm_rd_req | dm_wr_req) & ~dm_ready, combinationally.
REQ-030 A request withdrawn mid-access SHALL still complete, including the SRAM write and the ready pulse.
REQ-031 Outside ACCESS, sram_en and sram_we SHALL be 0; sram_addr and sram_wdata SHALL hold their last values.
REQ-032 if_rdata and dm_rdata SHALL hold their values until the next completed read of the same port.

Reset
REQ-033 When rst=0 at a rising edge, the block SHALL enter IDLE, set the counter to 0, and clear the last-grant flag to fetch.
REQ-034 On that reset, if_ready, dm_ready, sram_en and sram_we SHALL be 0; if_rdata, dm_rdata, sram_addr and sram_wdata SHALL be 0.
REQ-035 Reset during ACCESS or RESP SHALL abort the transfer: no ready pulse, and sram_en=0 from the next cycle.

Verification
REQ-036 Fetch only, WAIT_CYCLES=2: if_req=1, if_addr=0x6, SRAM word 4 = 0xE3A01004 -> sram_addr=0x4 in cycles 1-2; if_ready=1 and if_rdata=0xE3A01004 in cycle 3; freeze_if=1 in cycles 0-2.
REQ-037 Data write: dm_wr_req=1, dm_addr=0x400, dm_wdata=0x2000 -> sram_we=1 for 2 cycles at 0x400; dm_ready pulses in cycle 3; a following read of 0x400 returns 0x2000.
REQ-038 Contention: if_req and dm_rd_req both high from cycle 0 -> data granted first (dm_ready at cycle 3), fetch granted at cycle 4 (if_ready at cycle 7); freeze_if=1 in cycles 0-6.
REQ-039 Alternation under sustained load: both requests re-asserted after each ready -> grants alternate D, F, D, F with no starvation.
REQ-040 Reset abort: rst=0 in the second ACCESS cycle of a fetch -> no if_ready pulse; IDLE with sram_en=0 in the following cycle; a new request is served normally.
REQ-041 Parameter sweep: WAIT_CYCLES=1 and WAIT_CYCLES=7 -> ready at cycles 2 and 8 respectively, with sram_en high for exactly WAIT_CYCLES cycles.
